two_col_mac_accum: RTL and testbench
====================================

// Module: two_col_mac_accum
// PURPOSE
//  Accumulation stage directly downstream of the two-column INT8 DSP MAC. It tags operand issue, aligns
//  the MAC's 1-cycle registered product pair, and sums cfg_len products per group into two ACC_W lanes.
//  Completed group results go out on a valid/ready stream toward the requant/output stage.
//  Issue is throttled so a completed group is never dropped under output backpressure.
// PARAMETERS
//  PROD_W  16  width of each MAC product lane (signed, matches MAX_DW2)
//  CNT_W   16  width of length/group counters
//  ACC_W   32  accumulator width; required ACC_W >= PROD_W+CNT_W (no overflow possible, no saturation)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       pulse in IDLE: latch cfg_*, enter RUN; ignored when busy=1
//  cfg_len     in   CNT_W   products per group; 0 is treated as 1
//  cfg_groups  in   CNT_W   groups per job; 0 is treated as 1
//  busy        out  1       high from the cycle after start until done
//  done        out  1       one-cycle pulse when the job's last result has left the output FIFO
//  op_valid    in   1       upstream presents dat/wt to the MAC this cycle
//  op_ready    out  1       operand accepted when op_valid&op_ready (issue)
//  mac_sum0    in   PROD_W  MAC lane-0 product, valid 1 cycle after issue (signed)
//  mac_sum1    in   PROD_W  MAC lane-1 product, valid 1 cycle after issue (signed)
//  out_valid   out  1       head of output FIFO valid
//  out_ready   in   1       downstream accepts head
//  out_acc0    out  ACC_W   lane-0 group sum (signed)
//  out_acc1    out  ACC_W   lane-1 group sum (signed)
//  out_last    out  1       head is the job's final group
// BEHAVIOUR
//  Reset: FSM=IDLE, counters/acc/FIFO cleared; busy,done,op_ready,out_valid,out_last=0; out_acc*=0.
//  FSM: IDLE -start-> RUN; RUN -(final group's last operand issued)-> DRAIN;
//   DRAIN -(s1 empty & FIFO empty)-> IDLE with done=1 for that cycle. op_ready=0 outside RUN.
//  Issue stage: len_cnt counts issues within a group; grp_cnt counts groups. On issue, s1 tag <=
//   {valid, first=(len_cnt==0), last=(len_cnt==len-1), jlast=last&(grp_cnt==groups-1)}; s1 valid
//   otherwise 0. Counters wrap len_cnt to 0 on last issue and increment grp_cnt.
//  Accumulate stage (cycle after issue, aligned with mac_sum*): sign-extend products to ACC_W;
//   acc <= first ? prod : acc+prod. If last, {acc+prod (or prod if first), jlast} pushed to FIFO
//   in the same cycle; acc register not read again until next first.
//  MAC products are sampled only when s1 valid; non-issue cycles are ignored.
//  Output FIFO: 2 entries, show-ahead; push and pop same cycle allowed (occupancy unchanged).
//  op_ready = RUN & ((occ + s1.last) < 2); occ is current FIFO count. Guarantees no push into full FIFO;
//   cost: cfg_len=1 sustains 2 issues per 3 cycles with out_ready=1; cfg_len>=2 sustains full rate.
//  Latency: last issue at cycle T -> out_valid at T+2 (FIFO empty).
//  Arithmetic: two's complement, wrap never occurs given the ACC_W rule; lanes fully independent.
//  Boundaries: start with busy=1 ignored; op_valid in IDLE/DRAIN ignored; cfg_* changes after start
//   have no effect; rst_n low mid-job aborts: in-flight product and FIFO contents discarded.
//  out_acc*/out_last hold stable while out_valid&!out_ready.
// STRUCTURE
//  Shared package/defines: PROD_W (=MAX_DW2), ACC_W, CNT_W defaults, FSM state encoding localparams.
//  One sub-module: mac_accum_fifo2 (2-entry show-ahead FIFO, width 2*ACC_W+1, count output).
//  Issue counters, s1 tag register, accumulators, FSM in top.
// TESTING
//  T1 len=4,groups=1, lane0 prods 1,2,3,4, lane1 -1,-2,-3,-4, out_ready=1 -> acc0=10, acc1=-10, last=1, done.
//  T2 len=1,groups=6, out_ready=0 -> exactly 2 results queued, op_ready=0; release -> all 6 in order.
//  T3 len=65535, prods all -32768 -> acc0=-2147450880, no wrap; prods all 32767 -> 2147385345.
//  T4 len=3,groups=2, op_valid gaps between issues -> gaps ignored, sums correct, out_last only on 2nd.
//  T5 rst_n low while DRAIN with FIFO=1 -> all outputs 0 next edge; new start runs clean job.
//  T6 cfg_len=0,cfg_groups=0 + start during busy -> treated as 1x1; second start ignored, one done.

Source files
------------

// File: rtl/two_col_mac_accum_pkg.sv
// Purpose: shared widths, FSM encoding and record types for the two-column MAC accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package two_col_mac_accum_pkg;

  localparam int PROD_W = 16;  // one MAC product lane, signed (MAX_DW2)
  localparam int CNT_W  = 16;  // length / group counters
  localparam int ACC_W  = 32;  // must be >= PROD_W + CNT_W so a full group can never wrap

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Tag travelling alongside the MAC's one-cycle product register.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
    logic jlast;
  } tag_t;

  // One completed group as stored in the output FIFO.
  typedef struct packed {
    logic             last;
    logic [ACC_W-1:0] acc1;
    logic [ACC_W-1:0] acc0;
  } res_t;

  localparam int RES_W = $bits(res_t);

  // A zero length or group count behaves as one.
  function automatic logic [CNT_W-1:0] min1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/two_col_mac_accum_if.sv
// Purpose: control, operand-issue and result-stream bundle of the accumulator.
// Latency: n/a (wires only).
// Backpressure: op_valid/op_ready on issue, out_valid/out_ready on results.
// Ports: start/cfg_len/cfg_groups/busy/done (job control), op_valid/op_ready/mac_sum0/mac_sum1
//        (issue + aligned products), out_valid/out_ready/out_acc0/out_acc1/out_last (results).
interface two_col_mac_accum_if;
  import two_col_mac_accum_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  cfg_len;
  logic [CNT_W-1:0]  cfg_groups;
  logic              busy;
  logic              done;
  logic              op_valid;
  logic              op_ready;
  logic [PROD_W-1:0] mac_sum0;
  logic [PROD_W-1:0] mac_sum1;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc0;
  logic [ACC_W-1:0]  out_acc1;
  logic              out_last;

  modport master (
    output start, cfg_len, cfg_groups, op_valid, mac_sum0, mac_sum1, out_ready,
    input  busy, done, op_ready, out_valid, out_acc0, out_acc1, out_last
  );

  modport slave (
    input  start, cfg_len, cfg_groups, op_valid, mac_sum0, mac_sum1, out_ready,
    output busy, done, op_ready, out_valid, out_acc0, out_acc1, out_last
  );

endinterface

// File: rtl/mac_accum_fifo2.sv
// Purpose: 2-entry show-ahead FIFO holding completed group results.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens the same cycle; o_cnt lets the producer throttle.
// Ports: clk, rst_n, i_push/i_push_dat, i_pop, o_vld/o_dat (head), o_cnt (occupancy 0..2).
module mac_accum_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem0;  // head entry
  logic [W-1:0] r_mem1;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop & (r_cnt != 2'd0);
  assign w_push = i_push & ((r_cnt != 2'd2) | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_mem0 <= i_push_dat;
          else               r_mem1 <= i_push_dat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (r_cnt == 2'd1) begin
            r_mem0 <= i_push_dat;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_vld = (r_cnt != 2'd0);
  assign o_dat = r_mem0;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/two_col_mac_accum.sv
// Purpose: tags operand issue, aligns the MAC's registered product pair and sums cfg_len products per group.
// Latency: last issue at cycle T -> result at FIFO head in cycle T+2 (empty FIFO).
// Backpressure: op_ready throttles issue so a completed group always finds a FIFO slot.
// Ports: clk, rst_n (async, active low), bus (slave side of two_col_mac_accum_if).
module two_col_mac_accum
  import two_col_mac_accum_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  two_col_mac_accum_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_groups;
  logic [CNT_W-1:0] r_len_cnt;
  logic [CNT_W-1:0] r_grp_cnt;
  tag_t             r_s1;
  tag_t             w_tag;
  logic [ACC_W-1:0] r_acc0;
  logic [ACC_W-1:0] r_acc1;

  logic             w_op_ready;
  logic             w_issue;
  logic             w_last_op;
  logic             w_jlast_op;
  logic             w_done;
  logic [2:0]       w_occ_plus;
  logic [1:0]       w_occ;
  logic             w_fifo_vld;
  logic [ACC_W-1:0] w_prod0;
  logic [ACC_W-1:0] w_prod1;
  logic [ACC_W-1:0] w_sum0;
  logic [ACC_W-1:0] w_sum1;
  res_t             w_push_dat;
  res_t             w_head;

  // ---------------- issue stage ----------------
  // Counting a result still in s1 as already occupying a slot means a push never meets a full FIFO.
  assign w_occ_plus = {1'b0, w_occ} + {2'b00, r_s1.last};
  assign w_op_ready = (r_state == ST_RUN) & (w_occ_plus < 3'd2);
  assign w_issue    = bus.op_valid & w_op_ready;
  assign w_last_op  = (r_len_cnt == r_len - CNT_W'(1));
  assign w_jlast_op = w_last_op & (r_grp_cnt == r_groups - CNT_W'(1));

  always_comb begin
    w_tag = '0;
    if (w_issue) begin
      w_tag.vld   = 1'b1;
      w_tag.first = (r_len_cnt == '0);
      w_tag.last  = w_last_op;
      w_tag.jlast = w_jlast_op;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_issue && w_jlast_op) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_s1.vld && !w_fifo_vld) begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- counters, s1 tag, accumulators ----------------
  assign w_prod0 = {{(ACC_W-PROD_W){bus.mac_sum0[PROD_W-1]}}, bus.mac_sum0};
  assign w_prod1 = {{(ACC_W-PROD_W){bus.mac_sum1[PROD_W-1]}}, bus.mac_sum1};
  assign w_sum0  = r_s1.first ? w_prod0 : r_acc0 + w_prod0;
  assign w_sum1  = r_s1.first ? w_prod1 : r_acc1 + w_prod1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_groups  <= '0;
      r_len_cnt <= '0;
      r_grp_cnt <= '0;
      r_s1      <= '0;
      r_acc0    <= '0;
      r_acc1    <= '0;
    end else begin
      if (r_state == ST_IDLE && bus.start) begin
        r_len     <= min1(bus.cfg_len);
        r_groups  <= min1(bus.cfg_groups);
        r_len_cnt <= '0;
        r_grp_cnt <= '0;
      end else if (w_issue) begin
        if (w_last_op) begin
          r_len_cnt <= '0;
          r_grp_cnt <= r_grp_cnt + CNT_W'(1);
        end else begin
          r_len_cnt <= r_len_cnt + CNT_W'(1);
        end
      end
      r_s1 <= w_tag;
      // Products are only meaningful the cycle after an issue.
      if (r_s1.vld) begin
        r_acc0 <= w_sum0;
        r_acc1 <= w_sum1;
      end
    end
  end

  // ---------------- output FIFO ----------------
  always_comb begin
    w_push_dat      = '0;
    w_push_dat.last = r_s1.jlast;
    w_push_dat.acc1 = w_sum1;
    w_push_dat.acc0 = w_sum0;
  end

  mac_accum_fifo2 #(.W(RES_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_s1.vld & r_s1.last),
    .i_push_dat (w_push_dat),
    .i_pop      (bus.out_ready),
    .o_vld      (w_fifo_vld),
    .o_dat      (w_head),
    .o_cnt      (w_occ)
  );

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = w_done;
  assign bus.op_ready  = w_op_ready;
  assign bus.out_valid = w_fifo_vld;
  assign bus.out_acc0  = w_head.acc0;
  assign bus.out_acc1  = w_head.acc1;
  assign bus.out_last  = w_head.last;

endmodule

// File: tb/tb_two_col_mac_accum.sv
module tb_two_col_mac_accum;
  import two_col_mac_accum_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  two_col_mac_accum_if bus();

  two_col_mac_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_issued = 0;
  int n_done = 0;
  logic [PROD_W-1:0] op0 = '0;
  logic [PROD_W-1:0] op1 = '0;
  logic [ACC_W-1:0] q0[$];
  logic [ACC_W-1:0] q1[$];
  logic             ql[$];

  // Upstream MAC model: registered products one cycle after issue, junk otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mac_sum0 <= '0;
      bus.mac_sum1 <= '0;
    end else if (bus.op_valid && bus.op_ready) begin
      bus.mac_sum0 <= op0;
      bus.mac_sum1 <= op1;
      n_issued     <= n_issued + 1;
    end else begin
      bus.mac_sum0 <= 16'h5A5A;
      bus.mac_sum1 <= 16'hA5A5;
    end
  end

  // Result / done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q0.push_back(bus.out_acc0);
      q1.push_back(bus.out_acc1);
      ql.push_back(bus.out_last);
    end
    if (rst_n && bus.done) n_done++;
  end

  task automatic clear_q();
    q0.delete(); q1.delete(); ql.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int a, input int b);
    int w;
    bus.op_valid = 1'b1;
    op0 = PROD_W'(a);
    op1 = PROD_W'(b);
    w = 0;
    while (!bus.op_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.op_ready) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout op_ready=%0b required 1", bus.op_ready);
    end else begin
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
  endtask

  // Config is scrambled right after start to show it is latched.
  task automatic start_job(input int len, input int groups);
    bus.cfg_len    = CNT_W'(len);
    bus.cfg_groups = CNT_W'(groups);
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.cfg_len    = 16'd7;
    bus.cfg_groups = 16'd9;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (bus.busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (bus.busy) begin
      n_vec++; n_err++;
      $display("FAIL %s_idle_timeout busy=%0b required 0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.op_ready, bus.out_valid, bus.out_last} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got=%b required 00000", {bus.busy, bus.done, bus.op_ready, bus.out_valid, bus.out_last});
    end
    n_vec++;
    if ({bus.out_acc0, bus.out_acc1} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_acc got=%h/%h required 0/0", bus.out_acc0, bus.out_acc1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // T1: len=4 groups=1, also checks the T+2 latency.
  task automatic test_single_group();
    int d0;
    d0 = n_done;
    clear_q();
    bus.out_ready = 1'b1;
    start_job(4, 1);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL t1_busy got=%b required 1", bus.busy); end
    for (int k = 1; k <= 4; k++) issue(k, -k);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_valid got=%b required 0", bus.out_valid); end
    @(negedge clk);
    n_vec++;
    if ({bus.out_valid, bus.out_last, bus.out_acc0, bus.out_acc1} !== {1'b1, 1'b1, ACC_W'(10), ACC_W'(-10)}) begin
      n_err++;
      $display("FAIL t1_head got v=%b l=%b %0d/%0d required v=1 l=1 10/-10",
               bus.out_valid, bus.out_last, $signed(bus.out_acc0), $signed(bus.out_acc1));
    end
    wait_idle("t1");
    n_vec++;
    if ((n_done - d0) !== 1 || q0.size() !== 1) begin
      n_err++;
      $display("FAIL t1_done got done=%0d results=%0d required 1/1", n_done - d0, q0.size());
    end
  endtask

  // T2: len=1 groups=6 with output stalled, then released.
  task automatic test_backpressure();
    int d0, i0;
    d0 = n_done;
    i0 = n_issued;
    clear_q();
    bus.out_ready = 1'b0;
    start_job(1, 6);
    fork
      begin
        for (int k = 0; k < 6; k++) issue(10 * (k + 1), -(k + 1));
      end
      begin
        repeat (12) @(negedge clk);
        n_vec++;
        if (n_issued - i0 !== 2) begin n_err++; $display("FAIL t2_issued got=%0d required 2", n_issued - i0); end
        n_vec++;
        if (bus.op_ready !== 1'b0) begin n_err++; $display("FAIL t2_op_ready got=%b required 0", bus.op_ready); end
        n_vec++;
        if ({bus.out_valid, bus.out_last, bus.out_acc0, bus.out_acc1} !== {1'b1, 1'b0, ACC_W'(10), ACC_W'(-1)}) begin
          n_err++;
          $display("FAIL t2_held_head got v=%b l=%b %0d/%0d required v=1 l=0 10/-1",
                   bus.out_valid, bus.out_last, $signed(bus.out_acc0), $signed(bus.out_acc1));
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_idle("t2");
    n_vec++;
    if (q0.size() !== 6) begin
      n_err++;
      $display("FAIL t2_count got=%0d required 6", q0.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_vec++;
        if ({q0[k], q1[k], ql[k]} !== {ACC_W'(10 * (k + 1)), ACC_W'(-(k + 1)), (k == 5)}) begin
          n_err++;
          $display("FAIL t2_res%0d got %0d/%0d l=%b required %0d/%0d l=%b", k,
                   $signed(q0[k]), $signed(q1[k]), ql[k], 10 * (k + 1), -(k + 1), (k == 5));
        end
      end
    end
    n_vec++;
    if (n_done - d0 !== 1) begin n_err++; $display("FAIL t2_done got=%0d required 1", n_done - d0); end
  endtask

  // T3: longest group at extreme products; -32768*65535 = 0x80008000, 32767*65535 = 0x7FFE8001.
  task automatic test_wide_sum();
    time t0, t1;
    clear_q();
    bus.out_ready = 1'b1;
    start_job(65535, 1);
    t0 = $time;
    for (int k = 0; k < 65535; k++) issue(-32768, 32767);
    t1 = $time;
    n_vec++;
    if (t1 - t0 !== 65535 * 10) begin
      n_err++;
      $display("FAIL t3_rate got=%0d required %0d", t1 - t0, 65535 * 10);
    end
    wait_idle("t3");
    n_vec++;
    if (q0.size() !== 1 || {q0[0], q1[0], ql[0]} !== {32'h8000_8000, 32'd2147385345, 1'b1}) begin
      n_err++;
      $display("FAIL t3_sum got n=%0d %0d/%0d required -2147450880/2147385345", q0.size(), $signed(q0[0]), $signed(q1[0]));
    end
  endtask

  // T4: op_valid in IDLE ignored; len=3 groups=2 with idle gaps between issues.
  task automatic test_gaps();
    int i0;
    int a [6] = '{5, -3, 100, -200, 7, 1};
    int b [6] = '{7, 2, -50, 300, -8, 1};
    int g [6] = '{0, 2, 1, 3, 0, 2};
    clear_q();
    bus.out_ready = 1'b1;
    i0 = n_issued;
    bus.op_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.op_valid = 1'b0;
    n_vec++;
    if (bus.op_ready !== 1'b0 || n_issued !== i0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL t4_idle_op got ready=%b issued=%0d busy=%b required 0/0/0", bus.op_ready, n_issued - i0, bus.busy);
    end
    start_job(3, 2);
    for (int k = 0; k < 6; k++) begin
      repeat (g[k]) @(negedge clk);
      issue(a[k], b[k]);
    end
    wait_idle("t4");
    n_vec++;
    if (q0.size() !== 2) begin
      n_err++;
      $display("FAIL t4_count got=%0d required 2", q0.size());
    end else begin
      n_vec++;
      if ({q0[0], q1[0], ql[0]} !== {ACC_W'(102), ACC_W'(-41), 1'b0}) begin
        n_err++;
        $display("FAIL t4_grp0 got %0d/%0d l=%b required 102/-41 l=0", $signed(q0[0]), $signed(q1[0]), ql[0]);
      end
      n_vec++;
      if ({q0[1], q1[1], ql[1]} !== {ACC_W'(-192), ACC_W'(293), 1'b1}) begin
        n_err++;
        $display("FAIL t4_grp1 got %0d/%0d l=%b required -192/293 l=1", $signed(q0[1]), $signed(q1[1]), ql[1]);
      end
    end
  endtask

  // T5: reset while draining with one result queued, then a clean job.
  task automatic test_reset_midjob();
    clear_q();
    bus.out_ready = 1'b0;
    start_job(2, 1);
    issue(11, 12);
    issue(13, 14);
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.out_valid, bus.out_acc0} !== {1'b1, 1'b1, ACC_W'(24)}) begin
      n_err++;
      $display("FAIL t5_pre got busy=%b v=%b acc0=%0d required 1/1/24", bus.busy, bus.out_valid, bus.out_acc0);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.op_ready, bus.out_valid, bus.out_last, bus.out_acc0, bus.out_acc1} !== '0) begin
      n_err++;
      $display("FAIL t5_reset got busy=%b v=%b acc=%h/%h required all 0", bus.busy, bus.out_valid, bus.out_acc0, bus.out_acc1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_q();
    bus.out_ready = 1'b1;
    start_job(2, 1);
    issue(3, 4);
    issue(5, 6);
    wait_idle("t5");
    n_vec++;
    if (q0.size() !== 1 || {q0[0], q1[0], ql[0]} !== {ACC_W'(8), ACC_W'(10), 1'b1}) begin
      n_err++;
      $display("FAIL t5_clean got n=%0d %0d/%0d required 1 8/10", q0.size(), $signed(q0[0]), $signed(q1[0]));
    end
  endtask

  // T6: zero config acts as 1x1; a start while busy is ignored.
  task automatic test_zero_cfg();
    int d0;
    d0 = n_done;
    clear_q();
    bus.out_ready = 1'b1;
    start_job(0, 0);
    bus.cfg_len    = 16'd5;
    bus.cfg_groups = 16'd3;
    bus.start      = 1'b1;
    issue(9, -9);
    bus.start = 1'b0;
    wait_idle("t6");
    repeat (5) @(negedge clk);
    n_vec++;
    if (q0.size() !== 1 || {q0[0], q1[0], ql[0]} !== {ACC_W'(9), ACC_W'(-9), 1'b1}) begin
      n_err++;
      $display("FAIL t6_result got n=%0d %0d/%0d required 1 9/-9", q0.size(), $signed(q0[0]), $signed(q1[0]));
    end
    n_vec++;
    if (n_done - d0 !== 1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL t6_done got done=%0d busy=%b required 1/0", n_done - d0, bus.busy);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.cfg_len    = '0;
    bus.cfg_groups = '0;
    bus.op_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_single_group();
    test_backpressure();
    test_wide_sum();
    test_gaps();
    test_reset_midjob();
    test_zero_cfg();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
